frame_filter_seq: RTL and testbench

//  Parametrised pixel-sequencing filter engine, next generation of the single-mode src->dst copier.
//  On a start pulse it walks N pixels from a base address in a synchronous source RAM.
//  It applies a run-time-selected per-pixel operation (copy/gray/invert/threshold).
//  It writes each result to a destination RAM and signals done; it sits between two inferred RAMs.

---
 rtl/frame_filter_pkg.sv | 23 ++
 rtl/frame_filter_seq_pixel_op.sv | 41 ++++
 rtl/frame_filter_seq.sv | 146 ++++++++++++++
 tb/tb_frame_filter_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_filter_pkg.sv
// Shared encodings for the frame filter engine: operation modes, sequencer states
// and the fixed number of cycles spent on each pixel.
package frame_filter_pkg;

    typedef enum logic [1:0] {
        MODE_COPY = 2'b00,
        MODE_GRAY = 2'b01,
        MODE_INV  = 2'b10,
        MODE_THR  = 2'b11
    } mode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WT,
        ST_AP,
        ST_WR,
        ST_DONE
    } state_t;

    localparam int CYCLES_PER_PIXEL = 4;

endpackage

// File: rtl/frame_filter_seq_pixel_op.sv
// Combinational per-pixel operation: copy, channel-average gray, invert or gray threshold.
// Channel 0 sits in the least significant bits of the pixel word.
module pixel_op
    import frame_filter_pkg::*;
#(
    parameter int CH_BITS  = 8,
    parameter int CHANNELS = 3
) (
    input  mode_t                         mode,
    input  logic [CH_BITS-1:0]            threshold,
    input  logic [CH_BITS*CHANNELS-1:0]   pixel_in,
    output logic [CH_BITS*CHANNELS-1:0]   pixel_out
);

    localparam int SUM_W = CH_BITS + $clog2(CHANNELS);

    logic [SUM_W-1:0]   sum;
    logic [CH_BITS-1:0] gray;

    always_comb begin
        sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum = sum + SUM_W'(pixel_in[c*CH_BITS +: CH_BITS]);
        end
    end

    // The average of CHANNELS values never exceeds one channel, so truncation is lossless.
    assign gray = CH_BITS'(sum / SUM_W'(CHANNELS));

    always_comb begin
        pixel_out = pixel_in;
        case (mode)
            MODE_COPY: pixel_out = pixel_in;
            MODE_GRAY: pixel_out = {CHANNELS{gray}};
            MODE_INV:  pixel_out = ~pixel_in;
            MODE_THR:  pixel_out = (gray >= threshold) ? '1 : '0;
            default:   pixel_out = pixel_in;
        endcase
    end

endmodule

// File: rtl/frame_filter_seq.sv
// Pixel sequencer: walks N pixels from a sync source RAM through pixel_op into a destination RAM, 4 cycles/pixel.
// Optional FRAME_FILTER_CHECKSUM_EN adds a 16-bit wrapping sum of all channel values written per job.
module frame_filter_seq
    import frame_filter_pkg::*;
#(
    parameter int ADDR_BITS = 10,
    parameter int CH_BITS   = 8,
    parameter int CHANNELS  = 3
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [CH_BITS-1:0]            threshold,
    input  logic [ADDR_BITS-1:0]          src_base,
    input  logic [ADDR_BITS-1:0]          dst_base,
    input  logic [ADDR_BITS:0]            length,
    output logic [ADDR_BITS-1:0]          src_addr,
    input  logic [CH_BITS*CHANNELS-1:0]   src_rd_data,
    output logic [ADDR_BITS-1:0]          dst_addr,
    output logic [CH_BITS*CHANNELS-1:0]   dst_wr_data,
    output logic                          dst_we,
    output logic                          busy,
    output logic                          done
`ifdef FRAME_FILTER_CHECKSUM_EN
    ,
    output logic [15:0]                   checksum
`endif
);

    localparam int PIX_W = CH_BITS * CHANNELS;

    state_t                 state_q, state_d;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [ADDR_BITS:0]     len_q;
    logic [ADDR_BITS-1:0]   src_base_q, dst_base_q;
    mode_t                  mode_q;
    logic [CH_BITS-1:0]     thr_q;
    logic [PIX_W-1:0]       op_out;
    logic                   last_pix;

    assign last_pix = ({1'b0, idx_q} == (len_q - (ADDR_BITS+1)'(1)));

    pixel_op #(
        .CH_BITS  (CH_BITS),
        .CHANNELS (CHANNELS)
    ) u_pixel_op (
        .mode      (mode_q),
        .threshold (thr_q),
        .pixel_in  (src_rd_data),
        .pixel_out (op_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (length == '0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD:   state_d = ST_WT;
            ST_WT:   state_d = ST_AP;
            ST_AP:   state_d = ST_WR;
            ST_WR:   state_d = last_pix ? ST_DONE : ST_RD;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q == ST_RD) || (state_q == ST_WT) ||
                  (state_q == ST_AP) || (state_q == ST_WR);
    assign done = (state_q == ST_DONE);

    // Job parameters are captured on the accepting start so mid-job input changes are harmless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            len_q       <= '0;
            src_base_q  <= '0;
            dst_base_q  <= '0;
            mode_q      <= MODE_COPY;
            thr_q       <= '0;
            src_addr    <= '0;
            dst_addr    <= '0;
            dst_wr_data <= '0;
            dst_we      <= 1'b0;
        end else begin
            dst_we <= (state_q == ST_AP);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        idx_q      <= '0;
                        len_q      <= length;
                        src_base_q <= src_base;
                        dst_base_q <= dst_base;
                        mode_q     <= mode_t'(mode);
                        thr_q      <= threshold;
                        src_addr   <= src_base;
                    end
                end
                ST_AP: begin
                    dst_wr_data <= op_out;
                    dst_addr    <= dst_base_q + idx_q;
                end
                ST_WR: begin
                    if (!last_pix) begin
                        idx_q    <= idx_q + 1'b1;
                        src_addr <= src_base_q + idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FRAME_FILTER_CHECKSUM_EN
    logic [15:0] wr_sum;

    always_comb begin
        wr_sum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_sum = wr_sum + 16'(dst_wr_data[c*CH_BITS +: CH_BITS]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum <= '0;
        end else if (state_q == ST_IDLE && start) begin
            checksum <= '0;
        end else if (state_q == ST_WR) begin
            checksum <= checksum + wr_sum;
        end
    end
`endif

endmodule

// File: tb/tb_frame_filter_seq.sv
// Randomized scoreboard bench for frame_filter_seq: expected writes and done pulses are queued at issue
// time from a behavioural model and checked by an independent monitor on the falling edge.
module tb_frame_filter_seq;
    import frame_filter_pkg::*;

    localparam int AB    = 10;
    localparam int CB    = 8;
    localparam int CH    = 3;
    localparam int PW    = CB * CH;
    localparam int DEPTH = 1 << AB;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [1:0]      mode;
    logic [CB-1:0]   threshold;
    logic [AB-1:0]   src_base, dst_base;
    logic [AB:0]     length;
    logic [AB-1:0]   src_addr;
    logic [PW-1:0]   src_rd_data;
    logic [AB-1:0]   dst_addr;
    logic [PW-1:0]   dst_wr_data;
    logic            dst_we, busy, done;
`ifdef FRAME_FILTER_CHECKSUM_EN
    logic [15:0]     checksum;
`endif

    frame_filter_seq #(.ADDR_BITS(AB), .CH_BITS(CB), .CHANNELS(CH)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .threshold   (threshold),
        .src_base    (src_base),
        .dst_base    (dst_base),
        .length      (length),
        .src_addr    (src_addr),
        .src_rd_data (src_rd_data),
        .dst_addr    (dst_addr),
        .dst_wr_data (dst_wr_data),
        .dst_we      (dst_we),
        .busy        (busy),
        .done        (done)
`ifdef FRAME_FILTER_CHECKSUM_EN
        ,
        .checksum    (checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [PW-1:0] src_mem [DEPTH];
    always @(posedge clk) src_rd_data <= src_mem[src_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AB-1:0] addr;
        logic [PW-1:0] data;
        int            at;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_done[$];
    int  checks = 0;
    int  errors = 0;
    int  wr_seen = 0;
    int  done_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] ref_pix(input logic [1:0] m, input logic [CB-1:0] t,
                                              input logic [PW-1:0] p);
        int ch[CH];
        int g = 0;
        logic [PW-1:0] r = '0;
        for (int i = 0; i < CH; i++) begin
            ch[i] = int'((p >> (CB * i)) & PW'(255));
            g += ch[i];
        end
        g = g / CH;
        for (int i = 0; i < CH; i++) begin
            case (m)
                2'd0: r |= PW'(ch[i]) << (CB * i);
                2'd1: r |= PW'(g) << (CB * i);
                2'd2: r |= PW'(255 - ch[i]) << (CB * i);
                default: r |= PW'((g >= int'(t)) ? 255 : 0) << (CB * i);
            endcase
        end
        return r;
    endfunction

    wr_t mon_e;
    always @(negedge clk) begin
        if (!reset) begin
            if (dst_we) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h at cycle %0d", dst_addr, dst_wr_data, cyc);
                end else begin
                    mon_e = exp_wr.pop_front();
                    check("wr_addr", 64'(dst_addr), 64'(mon_e.addr));
                    check("wr_data", 64'(dst_wr_data), 64'(mon_e.data));
                    check("wr_cycle", 64'(cyc), 64'(mon_e.at));
                end
            end
            if (done) begin
                done_seen++;
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: at cycle %0d", cyc);
                end else begin
                    check("done_cycle", 64'(cyc), 64'(exp_done.pop_front()));
                    check("done_with_busy", 64'(busy), 64'(0));
                    check("writes_pending_at_done", 64'(exp_wr.size()), 64'(0));
                end
            end
        end
    end

    // poke >= 0 pulses an extra start that many cycles into the job; it must be ignored.
    task automatic run_job(input logic [1:0] m, input logic [CB-1:0] t, input logic [AB-1:0] sb,
                           input logic [AB-1:0] db, input int n, input int poke);
        int k;
        int d0;
        logic [PW-1:0] p;
        logic [15:0] ck = '0;
        wr_t e;
        @(negedge clk);
        k  = cyc + 1;
        d0 = done_seen;
        for (int i = 0; i < n; i++) begin
            p = ref_pix(m, t, src_mem[(int'(sb) + i) % DEPTH]);
            e.addr = AB'((int'(db) + i) % DEPTH);
            e.data = p;
            e.at   = k + CYCLES_PER_PIXEL * i + 3;
            exp_wr.push_back(e);
            for (int c = 0; c < CH; c++) ck = ck + 16'((p >> (CB * c)) & PW'(255));
        end
        exp_done.push_back(k + CYCLES_PER_PIXEL * n);
        mode = m; threshold = t; src_base = sb; dst_base = db; length = (AB+1)'(n);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        mode      = 2'($urandom);
        threshold = CB'($urandom);
        src_base  = AB'($urandom);
        dst_base  = AB'($urandom);
        length    = (AB+1)'($urandom_range(1, 8));
        for (int c = 0; c < CYCLES_PER_PIXEL * n + 20; c++) begin
            @(posedge clk);
            #1;
            start = (c == poke);
            if (done_seen != d0) break;
        end
        start = 1'b0;
        if (done_seen == d0) begin
            checks++;
            errors++;
            $display("FAIL job_timeout: no done for N=%0d started at cycle %0d", n, k);
            exp_wr.delete();
            exp_done.delete();
        end
`ifdef FRAME_FILTER_CHECKSUM_EN
        @(negedge clk);
        check("checksum", 64'(checksum), 64'(ck));
`endif
    endtask

    task automatic reset_mid_job();
        int w0;
        int d0;
        wr_t e;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e.addr = AB'(16'h100 + i);
            e.data = ref_pix(2'd2, 8'h00, src_mem[16'h40 + i]);
            e.at   = cyc + 1 + CYCLES_PER_PIXEL * i + 3;
            exp_wr.push_back(e);
        end
        w0 = wr_seen;
        d0 = done_seen;
        mode = 2'd2; src_base = 10'h040; dst_base = 10'h100; length = 11'd8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 40 && wr_seen < w0 + 2; c++) begin
            @(posedge clk);
            #1;
        end
        check("rst_two_writes_before_reset", 64'(wr_seen - w0), 64'(2));
        reset = 1'b1;
        #1;
        check("rst_mid_dst_we", 64'(dst_we), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_done", 64'(done), 64'(0));
        check("rst_mid_src_addr", 64'(src_addr), 64'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_no_more_writes", 64'(wr_seen - w0), 64'(2));
        check("rst_no_done", 64'(done_seen - d0), 64'(0));
        check("rst_idle_busy", 64'(busy), 64'(0));
        exp_wr.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mode = '0; threshold = '0;
        src_base = '0; dst_base = '0; length = '0;
        for (int i = 0; i < DEPTH; i++) src_mem[i] = PW'($urandom);
        #1;
        check("reset_src_addr", 64'(src_addr), 64'(0));
        check("reset_dst_addr", 64'(dst_addr), 64'(0));
        check("reset_dst_wr_data", 64'(dst_wr_data), 64'(0));
        check("reset_dst_we", 64'(dst_we), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        check("reset_done", 64'(done), 64'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;

        src_mem[0] = 24'h306090;
        run_job(2'd1, 8'h00, 10'h000, 10'h000, 1, -1);
        run_job(2'd2, 8'h00, 10'h000, 10'h020, 1, -1);
        run_job(2'd3, 8'h61, 10'h000, 10'h021, 1, -1);
        run_job(2'd3, 8'h60, 10'h000, 10'h022, 1, -1);
        src_mem[5] = 24'h123456;
        run_job(2'd0, 8'h00, 10'h005, 10'h023, 1, -1);
        src_mem[1] = 24'h306090;
        run_job(2'd1, 8'h00, 10'h000, 10'h030, 2, -1);
        run_job(2'd0, 8'h00, 10'h3FE, 10'h010, 4, -1);
        run_job(2'd2, 8'h00, 10'h100, 10'h200, 0, -1);
        run_job(2'd1, 8'h00, 10'h050, 10'h060, 5, 2);
        run_job(2'd0, 8'h00, 10'h070, 10'h080, 3, 11);
        run_job(2'd3, 8'h80, 10'h090, 10'h090, 6, -1);

        reset_mid_job();
        run_job(2'd1, 8'h00, 10'h040, 10'h100, 8, -1);

        for (int j = 0; j < 25; j++) begin
            run_job(2'($urandom), CB'($urandom), AB'($urandom), AB'($urandom),
                    $urandom_range(0, 24), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1);
        end
        run_job(2'($urandom), CB'($urandom), AB'($urandom), AB'($urandom), DEPTH, -1);

        repeat (20) @(negedge clk);
        if (exp_wr.size() != 0 || exp_done.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expectations: writes %0d done %0d", exp_wr.size(), exp_done.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
